// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory loader: geometry, state encoding, lane helpers.
package imem_loader_pkg;

  localparam int IMEM_AW        = 16;
  localparam int IMEM_DW        = 32;
  localparam int BYTES_PER_WORD = IMEM_DW / 8;
  localparam int BIDX_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // True when the byte index points at the most significant byte lane of a word.
  function automatic logic is_last_lane(input logic [BIDX_W-1:0] idx);
    return idx == BIDX_W'(BYTES_PER_WORD - 1);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte packer: byte k of a word lands in bits [8k+7:8k].
// o_word presents the word including the byte offered this cycle so the
// caller can capture a complete word on the same edge the last byte is taken.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_accept,
  input  logic [7:0]         i_byte,
  output logic [IMEM_DW-1:0] o_word,
  output logic               o_word_full
);

  logic [IMEM_DW-1:0] r_word;
  logic [BIDX_W-1:0]  r_idx;
  logic [BIDX_W+2:0]  w_lane_base;
  logic [IMEM_DW-1:0] w_word;

  assign w_lane_base = {r_idx, 3'b000};

  // Insert the incoming byte into its lane of the partially assembled word.
  always_comb begin
    w_word              = r_word;
    w_word[w_lane_base +: 8] = i_byte;
  end

  assign o_word      = w_word;
  assign o_word_full = i_accept & is_last_lane(r_idx);

  // Byte lane register and index; restart at lane 0 after a full word or on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= {IMEM_DW{1'b0}};
      r_idx  <= {BIDX_W{1'b0}};
    end else if (i_clear) begin
      r_word <= {IMEM_DW{1'b0}};
      r_idx  <= {BIDX_W{1'b0}};
    end else if (i_accept) begin
      if (is_last_lane(r_idx)) begin
        r_word <= {IMEM_DW{1'b0}};
        r_idx  <= {BIDX_W{1'b0}};
      end else begin
        r_word <= w_word;
        r_idx  <= r_idx + BIDX_W'(1);
      end
    end else begin
      r_word <= r_word;
      r_idx  <= r_idx;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: streams bytes into words and writes them to
// consecutive word addresses, holding the core in reset until the load ends.
// Every output is a flop so no input reaches an output combinationally.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [IMEM_AW-1:0] i_base_addr,
  input  logic [IMEM_AW-1:0] i_word_count,
  input  logic               i_byte_valid,
  input  logic [7:0]         i_byte_data,
  output logic               o_byte_ready,
  output logic               o_we,
  output logic [IMEM_AW-1:0] o_waddr,
  output logic [IMEM_DW-1:0] o_wdata,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_cpu_hold
);

  state_t             r_state;
  logic [IMEM_AW-1:0] r_addr;
  logic [IMEM_AW-1:0] r_remaining;
  logic               r_byte_ready;
  logic               r_we;
  logic [IMEM_AW-1:0] r_waddr;
  logic [IMEM_DW-1:0] r_wdata;
  logic               r_busy;
  logic               r_done;
  logic               r_cpu_hold;

  logic               w_accept;
  logic               w_clear;
  logic               w_word_full;
  logic [IMEM_DW-1:0] w_word;

  // A byte is only taken while the registered ready is up (RECV).
  assign w_accept = i_byte_valid & r_byte_ready;
  assign w_clear  = (r_state == ST_IDLE) & i_start;

  imem_word_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_accept    (w_accept),
    .i_byte      (i_byte_data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  // Load sequencer with counters; outputs are set alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= {IMEM_AW{1'b0}};
      r_remaining  <= {IMEM_AW{1'b0}};
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= {IMEM_AW{1'b0}};
      r_wdata      <= {IMEM_DW{1'b0}};
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cpu_hold   <= 1'b1;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_addr      <= i_base_addr;
            r_remaining <= i_word_count;
            r_cpu_hold  <= 1'b1;
            r_busy      <= 1'b1;
            if (i_word_count == {IMEM_AW{1'b0}}) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= ST_RECV;
              r_byte_ready <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RECV: begin
          if (w_word_full) begin
            r_state      <= ST_WRITE;
            r_byte_ready <= 1'b0;
            r_we         <= 1'b1;
            r_waddr      <= r_addr;
            r_wdata      <= w_word;
          end else begin
            r_state <= ST_RECV;
          end
        end
        ST_WRITE: begin
          r_addr      <= r_addr + IMEM_AW'(1);
          r_remaining <= r_remaining - IMEM_AW'(1);
          if (r_remaining == IMEM_AW'(1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state      <= ST_RECV;
            r_byte_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_cpu_hold   <= 1'b0;
          r_byte_ready <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_byte_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_we         = r_we;
  assign o_waddr      = r_waddr;
  assign o_wdata      = r_wdata;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_cpu_hold   = r_cpu_hold;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a byte source driver plus an
// expected-write list built from the load parameters and the byte stream.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start = 1'b0;
  logic [15:0] i_base_addr = 16'h0;
  logic [15:0] i_word_count = 16'h0;
  logic        i_byte_valid = 1'b0;
  logic [7:0]  i_byte_data = 8'h0;
  logic        o_byte_ready, o_we, o_busy, o_done, o_cpu_hold;
  logic [15:0] o_waddr;
  logic [31:0] o_wdata;

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  imem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_word_count (i_word_count),
    .i_byte_valid (i_byte_valid),
    .i_byte_data  (i_byte_data),
    .o_byte_ready (o_byte_ready),
    .o_we         (o_we),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_cpu_hold   (o_cpu_hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Runs one load; gap_mode 0 = valid always, 1 = every other cycle, 2 = random.
  task automatic run_load(input string name, input logic [15:0] base, input logic [15:0] count,
                          input logic [7:0] bytes[$], input int gap_mode,
                          input int start_pulse_at, input int reset_after);
    logic [15:0] got_addr[$];
    logic [31:0] got_data[$];
    int unsigned got_cyc[$];
    int unsigned last_cyc[$];
    int unsigned c0, done_cyc, exp_done;
    int done_cnt, idx, ready_seen, nwords, k;
    bit v, finished, was_reset;
    logic [15:0] exp_addr;
    logic [31:0] exp_data;
    done_cnt = 0; idx = 0; ready_seen = 0; finished = 0; was_reset = 0; done_cyc = 0;
    nwords = (reset_after >= 0) ? reset_after / 4 : int'(count);

    @(negedge clk);
    c0 = cyc;
    i_base_addr = base; i_word_count = count; i_start = 1'b1; i_byte_valid = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    n_checks++;
    if ({o_busy, o_byte_ready} !== {1'b1, count != 16'h0})
      $display("FAIL %s start_response busy/ready got %b expected %b", name,
               {o_busy, o_byte_ready}, {1'b1, count != 16'h0});
    else n_pass++;

    k = 0;
    while (!finished && k < 4000) begin
      if (o_we) begin
        got_addr.push_back(o_waddr); got_data.push_back(o_wdata); got_cyc.push_back(cyc);
      end
      if (o_byte_ready) ready_seen++;
      if (o_done) begin
        done_cnt++; done_cyc = cyc;
        n_checks++;
        if (o_cpu_hold !== 1'b1) $display("FAIL %s hold_at_done got %b expected 1", name, o_cpu_hold);
        else n_pass++;
      end
      if (done_cnt > 0 && cyc == done_cyc + 1) begin
        n_checks++;
        if ({o_cpu_hold, o_busy} !== 2'b00)
          $display("FAIL %s hold_busy_after_done got %b expected 00", name, {o_cpu_hold, o_busy});
        else n_pass++;
        finished = 1'b1;
      end else if (reset_after >= 0 && idx == reset_after) begin
        rst_n = 1'b0; i_byte_valid = 1'b0;
        #1;
        n_checks++;
        if ({o_byte_ready, o_we, o_waddr, o_wdata, o_busy, o_done, o_cpu_hold} !==
            {1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1})
          $display("FAIL %s reset_values got rdy=%b we=%b a=%h d=%h busy=%b done=%b hold=%b expected 0 0 0000 00000000 0 0 1",
                   name, o_byte_ready, o_we, o_waddr, o_wdata, o_busy, o_done, o_cpu_hold);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
          i_byte_valid = 1'b1; i_byte_data = 8'($urandom);
          @(negedge clk);
          n_checks++;
          if ({o_we, o_busy, o_byte_ready, o_cpu_hold} !== 4'b0001)
            $display("FAIL %s post_reset_idle we/busy/rdy/hold got %b expected 0001", name,
                     {o_we, o_busy, o_byte_ready, o_cpu_hold});
          else n_pass++;
        end
        i_byte_valid = 1'b0;
        was_reset = 1'b1; finished = 1'b1;
      end else begin
        i_start = (k == start_pulse_at);
        if (k == start_pulse_at) begin
          i_base_addr = base ^ 16'h5555; i_word_count = 16'd7;
        end
        case (gap_mode)
          0: v = 1'b1;
          1: v = (k % 2 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        if (idx >= bytes.size()) v = 1'b0;
        i_byte_valid = v;
        i_byte_data  = v ? bytes[idx] : 8'($urandom);
        if (v && o_byte_ready) begin
          if (idx % 4 == 3) last_cyc.push_back(cyc);
          idx++;
        end
        @(negedge clk);
        k++;
      end
    end
    i_byte_valid = 1'b0; i_start = 1'b0;

    n_checks++;
    if (!finished) $display("FAIL %s timeout got no completion expected done within 4000 cycles", name);
    else n_pass++;

    n_checks++;
    if (got_addr.size() != nwords)
      $display("FAIL %s write_count got %0d expected %0d", name, got_addr.size(), nwords);
    else n_pass++;

    for (int w = 0; w < nwords && w < got_addr.size(); w++) begin
      exp_addr = base + 16'(w);
      exp_data = 32'h0;
      for (int b = 0; b < 4; b++) exp_data = exp_data | (32'(bytes[4*w+b]) << (8*b));
      n_checks++;
      if (got_addr[w] !== exp_addr || got_data[w] !== exp_data)
        $display("FAIL %s write%0d got %h@%h expected %h@%h", name, w, got_data[w], got_addr[w],
                 exp_data, exp_addr);
      else n_pass++;
      n_checks++;
      if (w >= last_cyc.size() || got_cyc[w] != last_cyc[w] + 1)
        $display("FAIL %s we_timing%0d got cycle %0d expected one after last byte", name, w, got_cyc[w]);
      else n_pass++;
    end

    if (!was_reset) begin
      exp_done = (count == 16'h0) ? c0 + 1 :
                 ((last_cyc.size() > 0) ? last_cyc[last_cyc.size()-1] + 2 : 0);
      n_checks++;
      if (done_cnt != 1 || done_cyc != exp_done)
        $display("FAIL %s done_pulse got %0d pulses at %0d expected 1 at %0d", name, done_cnt,
                 done_cyc, exp_done);
      else n_pass++;
      n_checks++;
      if (idx != 4 * int'(count))
        $display("FAIL %s bytes_consumed got %0d expected %0d", name, idx, 4 * int'(count));
      else n_pass++;
      if (count == 16'h0) begin
        n_checks++;
        if (ready_seen != 0) $display("FAIL %s zero_ready got %0d expected 0", name, ready_seen);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_byte_valid = 1'b1; i_byte_data = 8'hA5;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_byte_ready, o_we, o_waddr, o_wdata, o_busy, o_done, o_cpu_hold} !==
        {1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_values got rdy=%b we=%b a=%h d=%h busy=%b done=%b hold=%b expected 0 0 0000 00000000 0 0 1",
               o_byte_ready, o_we, o_waddr, o_wdata, o_busy, o_done, o_cpu_hold);
    else n_pass++;
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_checks++;
      if ({o_cpu_hold, o_busy, o_byte_ready, o_we} !== 4'b1000)
        $display("FAIL idle_before_start hold/busy/rdy/we got %b expected 1000",
                 {o_cpu_hold, o_busy, o_byte_ready, o_we});
      else n_pass++;
    end
    i_byte_valid = 1'b0;
  endtask

  task automatic test_program();
    logic [7:0] q[$];
    q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    run_load("program", 16'h0000, 16'd3, q, 0, -1, -1);
  endtask

  task automatic test_gapped();
    logic [7:0] q[$];
    q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    run_load("gapped", 16'h0000, 16'd3, q, 1, -1, -1);
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    run_load("wrap", 16'hFFFF, 16'd2, q, 0, -1, -1);
  endtask

  task automatic test_zero();
    logic [7:0] q[$];
    run_load("zero", 16'h1234, 16'd0, q, 0, -1, -1);
  endtask

  task automatic test_start_ignored_and_reset();
    logic [7:0] q[$];
    for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
    run_load("midreset", 16'h0100, 16'd3, q, 0, 1, 6);
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [15:0] cnt;
    for (int t = 0; t < 5; t++) begin
      q.delete();
      cnt = 16'($urandom_range(1, 5));
      for (int i = 0; i < 4 * int'(cnt) + 4; i++) q.push_back(8'($urandom));
      run_load("random", 16'($urandom), cnt, q, 2, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_gapped();
    test_wrap();
    test_zero();
    test_start_ignored_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction memory loader: receives a program as a byte stream over a valid/ready handshake, packs bytes little-endian into instruction words and writes them sequentially into the instruction memory write port. It is the writer side of the instruction memory, which the fetch path only reads. It sits between the boot/debug byte source and the instruction memory, and holds the core in reset via `cpu_hold` until a load completes.

## Interface
- `m`, 16, instruction memory address width (word address)
- `n`, 32, instruction word width; must be a multiple of 8 (`n/8` bytes per word)

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  load request, sampled in IDLE only
- `base_addr`  in  m  first word address, latched on accepted `start`
- `word_count`  in  m  number of words to load, latched on accepted `start`
- `byte_valid`  in  1  source has a byte
- `byte_data`  in  8  byte payload
- `byte_ready`  out  1  loader accepts a byte this cycle
- `we`  out  1  instruction memory write enable
- `waddr`  out  m  write word address
- `wdata`  out  n  write data
- `busy`  out  1  load in progress (state not IDLE)
- `done`  out  1  one-cycle pulse at end of load
- `cpu_hold`  out  1  keep core in reset

## Operation
- One clock; reset is asynchronous and active-low.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE: `byte_ready`=0. On `start`=1: latch `base_addr` into address counter and `word_count` into remaining counter, clear byte index, set `cpu_hold`=1; go DONE if `word_count`==0, else RECV.
- RECV: `byte_ready`=1. Byte is accepted when `byte_valid`&`byte_ready`. Byte k of a word (k=0 first) goes to `wdata[8k+7:8k]`. Accepting byte `n/8-1` moves to WRITE.
- WRITE: `we`=1 for exactly one cycle with `waddr`=address counter and the assembled `wdata`; `byte_ready`=0. Address counter increments by 1, modulo 2^m (wraps 0xFFFF->0x0000). Remaining counter decrements. Go DONE if remaining was 1, else RECV.
- DONE: `done`=1 for one cycle, `cpu_hold` cleared; go IDLE.
- `start` outside IDLE is ignored. `byte_valid` outside RECV is not accepted (no bytes are dropped; the source holds them).
- `wdata`/`waddr` hold their last values when `we`=0.

## Timing
- Reset values: state IDLE, `byte_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `busy`=0, `done`=0, `cpu_hold`=1 (core held from power-up until the first `done`).
- All outputs are registered or decoded from state only; no combinational path from `byte_valid` to `byte_ready`.
- `start` in cycle t -> `busy`=1 and `byte_ready`=1 in cycle t+1 (RECV).
- Last byte of a word accepted in cycle t -> `we`=1 in cycle t+1.
- Throughput: one word per `n/8`+1 cycles with `byte_valid` held high (5 cycles for n=32).
- Final `we` in cycle t -> `done`=1 in cycle t+1, `cpu_hold`=0 from cycle t+2, `busy`=0 from cycle t+2.
- `word_count`=0: `start` in cycle t -> `done` in cycle t+1, no `we`.
- Reset mid-load: immediate return to reset values; partial word discarded; words already written remain in memory.

## Structure
- Shared package: state encoding (IDLE, RECV, WRITE, DONE), constant `BYTES_PER_WORD = n/8`, byte index width.
- One sub-module: `imem_word_packer` (byte-lane shift/insert register plus byte index, with an `accept` input and a `word_full` output); FSM and address/remaining counters live in `imem_loader`.

## Test plan
- Reset then `start` with base 0x0000, count 3, bytes 13 00 00 00 / 93 00 10 00 / 13 01 20 00 streamed with no gaps -> writes 0x00000013@0x0000, 0x00100093@0x0001, 0x00200113@0x0002; single `done`; `cpu_hold` falls 2 cycles after the last `we`.
- Same load with `byte_valid` toggling every other cycle -> identical writes; `we` only one cycle after each 4th accepted byte.
- base 0xFFFF, count 2 -> writes at 0xFFFF then 0x0000.
- count 0 -> `done` one cycle after `start`, no `we`, `byte_ready` never high.
- `start` pulsed during RECV, and `rst_n` asserted after 2 bytes of word 1 -> second `start` ignored; after reset: all outputs at reset values, `cpu_hold`=1, no `we` for the partial word.
- Reset value check: `cpu_hold`=1, `busy`=0, `byte_ready`=0 from reset until the first `start`.
